// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, next-PC load, instruction-memory
// addressing, plus a program-load write sequencer and a fetch-freezing halt.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       npc,
    input  logic              halt,
    input  logic              program_load,
    output logic [31:0]       pc,
    output logic [ADDR_W-1:0] pc_mem,
    output logic              i_write,
    output logic              i_enable
);

    logic [31:0]       pc_q;
    logic [31:0]       pc_d;
    logic [ADDR_W-1:0] load_cnt_q;
    logic [ADDR_W-1:0] load_cnt_d;
    logic [31:0]       pc_word;

    // Priority below reset: program_load > halt > normal fetch.
    always_comb begin
        pc_d       = pc_q;
        load_cnt_d = load_cnt_q;
        if (program_load) begin
            load_cnt_d = load_cnt_q + ADDR_W'(1);
        end else begin
            // Counter restarts from word 0 on the next load burst.
            load_cnt_d = '0;
            if (!halt) begin
                pc_d = npc & ~32'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            load_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    assign pc_word = {2'b00, pc_q[31:2]};
    assign pc      = pc_q;

    // Memory strobes are combinational so the address tracks pc in the same cycle.
    always_comb begin
        pc_mem   = ADDR_W'(pc_word);
        i_enable = 1'b0;
        i_write  = 1'b0;
        if (reset) begin
            if (program_load) begin
                pc_mem   = load_cnt_q;
                i_enable = 1'b1;
                i_write  = 1'b1;
            end else if (!halt) begin
                i_enable = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Scoreboard bench for if_stage_fetch: directed steps push hand-computed
// expectations; a monitor samples the outputs once per cycle and compares.
module tb_if_stage_fetch;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic [31:0]       npc;
    logic              halt;
    logic              program_load;
    logic [31:0]       pc;
    logic [ADDR_W-1:0] pc_mem;
    logic              i_write;
    logic              i_enable;

    typedef struct {
        logic [31:0]       pc;
        logic [ADDR_W-1:0] mem;
        logic              en;
        logic              wr;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    if_stage_fetch #(.RESET_PC(32'd0), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .npc          (npc),
        .halt         (halt),
        .program_load (program_load),
        .pc           (pc),
        .pc_mem       (pc_mem),
        .i_write      (i_write),
        .i_enable     (i_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 ns after a rising edge; expectations describe the
    // outputs seen during that cycle (before the next rising edge).
    task automatic step(input logic r, input logic pl, input logic h,
                        input logic [31:0] n, input logic [31:0] e_pc,
                        input logic [31:0] e_mem, input logic e_en,
                        input logic e_wr, input string nm);
        exp_t e;
        @(posedge clk);
        #2;
        reset        = r;
        program_load = pl;
        halt         = h;
        npc          = n;
        e.pc  = e_pc;
        e.mem = ADDR_W'(e_mem);
        e.en  = e_en;
        e.wr  = e_wr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one observation per cycle on the falling edge.
    always begin
        exp_t  e;
        string nm;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (pc !== e.pc || pc_mem !== e.mem || i_enable !== e.en || i_write !== e.wr) begin
                errors++;
                $display("FAIL %s: got pc=%0d pc_mem=%0d en=%0b wr=%0b, expected pc=%0d pc_mem=%0d en=%0b wr=%0b",
                         nm, pc, pc_mem, i_enable, i_write, e.pc, e.mem, e.en, e.wr);
            end else begin
                $display("ok   %s: pc=%0d pc_mem=%0d en=%0b wr=%0b", nm, pc, pc_mem, i_enable, i_write);
            end
        end
    end

    initial begin
        reset        = 1'b0;
        program_load = 1'b0;
        halt         = 1'b0;
        npc          = 32'd10000;

        //    rst  pl   halt  npc            pc             pc_mem        en    wr
        step(1'b0, 1'b0, 1'b0, 32'd10000,    32'd0,         32'd0,        1'b0, 1'b0, "reset_1");
        step(1'b0, 1'b0, 1'b0, 32'd10000,    32'd0,         32'd0,        1'b0, 1'b0, "reset_2");
        step(1'b1, 1'b0, 1'b0, 32'd10000,    32'd0,         32'd0,        1'b1, 1'b0, "release");
        step(1'b1, 1'b0, 1'b0, 32'd10000,    32'd10000,     32'd2500,     1'b1, 1'b0, "fetch_10000");
        step(1'b1, 1'b0, 1'b0, 32'd10000,    32'd10000,     32'd2500,     1'b1, 1'b0, "hold_1");
        step(1'b1, 1'b0, 1'b0, 32'd10100,    32'd10000,     32'd2500,     1'b1, 1'b0, "hold_2");
        step(1'b1, 1'b0, 1'b0, 32'd10103,    32'd10100,     32'd2525,     1'b1, 1'b0, "fetch_10100");
        step(1'b1, 1'b0, 1'b0, 32'd10103,    32'd10100,     32'd2525,     1'b1, 1'b0, "align_10103");
        step(1'b1, 1'b0, 1'b1, 32'd20000,    32'd10100,     32'd2525,     1'b0, 1'b0, "halt_1");
        step(1'b1, 1'b0, 1'b1, 32'd20000,    32'd10100,     32'd2525,     1'b0, 1'b0, "halt_2");
        step(1'b1, 1'b0, 1'b1, 32'd20000,    32'd10100,     32'd2525,     1'b0, 1'b0, "halt_3");
        step(1'b1, 1'b0, 1'b0, 32'd20000,    32'd10100,     32'd2525,     1'b1, 1'b0, "unhalt");
        step(1'b1, 1'b0, 1'b0, 32'd20000,    32'd20000,     32'd5000,     1'b1, 1'b0, "fetch_20000");
        step(1'b1, 1'b1, 1'b0, 32'd20000,    32'd20000,     32'd0,        1'b1, 1'b1, "load_0");
        step(1'b1, 1'b1, 1'b0, 32'd20000,    32'd20000,     32'd1,        1'b1, 1'b1, "load_1");
        step(1'b1, 1'b1, 1'b0, 32'd20000,    32'd20000,     32'd2,        1'b1, 1'b1, "load_2");
        step(1'b1, 1'b1, 1'b0, 32'd20000,    32'd20000,     32'd3,        1'b1, 1'b1, "load_3");
        step(1'b1, 1'b0, 1'b0, 32'd20000,    32'd20000,     32'd5000,     1'b1, 1'b0, "load_end");
        step(1'b1, 1'b1, 1'b0, 32'd20000,    32'd20000,     32'd0,        1'b1, 1'b1, "reload_0");
        step(1'b1, 1'b1, 1'b0, 32'd20000,    32'd20000,     32'd1,        1'b1, 1'b1, "reload_1");
        step(1'b1, 1'b1, 1'b1, 32'd20000,    32'd20000,     32'd2,        1'b1, 1'b1, "load_over_halt");
        step(1'b0, 1'b1, 1'b1, 32'd30000,    32'd20000,     32'd5000,     1'b0, 1'b0, "reset_mid_load");
        step(1'b0, 1'b1, 1'b1, 32'd30000,    32'd0,         32'd0,        1'b0, 1'b0, "reset_held");
        step(1'b1, 1'b1, 1'b0, 32'd30000,    32'd0,         32'd0,        1'b1, 1'b1, "load_after_reset");
        step(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd0,         32'd0,        1'b1, 1'b0, "wrap_apply");
        step(1'b1, 1'b0, 1'b0, 32'd4,        32'hFFFFFFFC,  32'h3FFFFFFF, 1'b1, 1'b0, "wrap_top");
        step(1'b1, 1'b0, 1'b0, 32'd4,        32'd4,         32'd1,        1'b1, 1'b0, "after_wrap");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
